// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types and widths for the data-memory port arbiter
// DMEM_ARB_STATS_EN adds the statistics counter widths.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC_A = 2'd1,
        ST_ACC_B = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int CNT_W = 4;

`ifdef DMEM_ARB_STATS_EN
    localparam int STAT_W = 16;
    localparam int WAIT_W = 8;
`endif

endpackage

// File: rtl/dmem_arb_rr.sv
// rtl/dmem_arb_rr.sv - combinational 2-way round-robin picker (bit 0 = port A, bit 1 = port B)
module dmem_arb_rr
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] gnt
);

    logic [1:0] elig;

    always_comb begin
        elig = req & ~mask;
        gnt  = elig;
        // On a tie the port that did not win last time goes next.
        if (elig == 2'b11) begin
            gnt = (last == PORT_B) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-master sequencer for the single-port data memory
// Define DMEM_ARB_STATS_EN to add a_grants/b_grants/b_wait_max statistics outputs.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [DW-1:0]         a_wdata,
    output logic                  a_ack,
    output logic [DW-1:0]         a_rdata,
    output logic                  a_stall,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [AW-1:0]         b_addr,
    input  logic [DW-1:0]         b_wdata,
    output logic                  b_ack,
    output logic [DW-1:0]         b_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic [DW-1:0]         mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [STAT_W-1:0]     a_grants,
    output logic [STAT_W-1:0]     b_grants,
    output logic [WAIT_W-1:0]     b_wait_max,
`endif
    output logic                  busy
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             we_q, we_d;
    logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DW-1:0]    a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic [1:0]       gnt;
    logic             can_grant;

    // The acked port still shows req high during its ack cycle, so mask it there.
    dmem_arb_rr u_rr (
        .req  ({b_req, a_req}),
        .mask ({b_ack_q, a_ack_q}),
        .last (last_q),
        .gnt  (gnt)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] a_grants_q, a_grants_d, b_grants_q, b_grants_d;
    logic [WAIT_W-1:0] b_wait_q, b_wait_d, b_wait_max_q, b_wait_max_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        we_d        = we_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        can_grant   = (state_q == ST_IDLE) || a_ack_q || b_ack_q;

        if (state_q != ST_IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                if (state_q == ST_ACC_A) begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = mem_rdata;
                end else begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = mem_rdata;
                end
            end
        end

        // Granting from the ack cycle gives back-to-back accesses with no idle bubble.
        if (can_grant) begin
            if (gnt[0]) begin
                state_d     = ST_ACC_A;
                last_d      = PORT_A;
                we_d        = a_we;
                mem_addr_d  = a_addr;
                mem_wdata_d = a_wdata;
            end else if (gnt[1]) begin
                state_d     = ST_ACC_B;
                last_d      = PORT_B;
                we_d        = b_we;
                mem_addr_d  = b_addr;
                mem_wdata_d = b_wdata;
            end else begin
                state_d     = ST_IDLE;
            end
            if (|gnt) begin
                mem_en_d = 1'b1;
                mem_we_d = we_d;
                cnt_d    = LAT_INIT;
            end
        end

`ifdef DMEM_ARB_STATS_EN
        a_grants_d   = a_grants_q;
        b_grants_d   = b_grants_q;
        b_wait_d     = '0;
        b_wait_max_d = b_wait_max_q;
        if (can_grant && gnt[0] && a_grants_q != '1) a_grants_d = a_grants_q + 1'b1;
        if (can_grant && gnt[1] && b_grants_q != '1) b_grants_d = b_grants_q + 1'b1;
        // A B cycle counts as waiting while B asks, is not being served, and is not granted now.
        if (b_req && state_q != ST_ACC_B && !(can_grant && gnt[1])) begin
            b_wait_d = (b_wait_q != '1) ? b_wait_q + 1'b1 : b_wait_q;
            if (b_wait_d > b_wait_max_q) b_wait_max_d = b_wait_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_q       <= PORT_B;
            we_q         <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef DMEM_ARB_STATS_EN
            a_grants_q   <= '0;
            b_grants_q   <= '0;
            b_wait_q     <= '0;
            b_wait_max_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            we_q         <= we_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef DMEM_ARB_STATS_EN
            a_grants_q   <= a_grants_d;
            b_grants_q   <= b_grants_d;
            b_wait_q     <= b_wait_d;
            b_wait_max_q <= b_wait_max_d;
`endif
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_stall   = a_req & ~a_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef DMEM_ARB_STATS_EN
    assign a_grants   = a_grants_q;
    assign b_grants   = b_grants_q;
    assign b_wait_max = b_wait_max_q;
`endif

endmodule
